// File: rtl/ascii_rx_pkg.sv
// Shared types and constants for the ASCII serial receiver.
// ASCII_RX_PARITY_EN adds the PARITY state (8E1 frames).
package ascii_rx_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef ASCII_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic evenParity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;
`endif

endpackage

// File: rtl/ascii_uart_rx_if.sv
// Parallel byte handshake and status flags between the receiver and its consumer.
// ASCII_RX_PARITY_EN adds the parity_err flag.
interface ascii_uart_rx_if;

  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef ASCII_RX_PARITY_EN
  logic       parity_err;

  modport master (output data, data_valid, busy, frame_err, overrun, parity_err,
                  input  data_ready);
  modport slave  (input  data, data_valid, busy, frame_err, overrun, parity_err,
                  output data_ready);
`else
  modport master (output data, data_valid, busy, frame_err, overrun,
                  input  data_ready);
  modport slave  (input  data, data_valid, busy, frame_err, overrun,
                  output data_ready);
`endif

endinterface

// File: rtl/ascii_rx_baud_cnt.sv
// Bit-timing down-counter: loaded with a half or full bit period, ticks for one
// cycle on the count that brings it to zero.
module ascii_rx_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_loadHalf,
  input  logic i_loadFull,
  output logic o_tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

  logic [CW-1:0] r_count;

  // The tick is taken at count 1 so a load made in cycle E ticks at E + load value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_loadFull) begin
      r_count <= FULL;
    end else if (i_loadHalf) begin
      r_count <= HALF;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_tick = (r_count == CW'(1));

endmodule

// File: rtl/ascii_uart_rx.sv
// Oversampling serial receiver feeding the ASCII case converter over a valid/ready bus.
// ASCII_RX_PARITY_EN selects 8E1 frames with a parity check; otherwise 8N1.
module ascii_uart_rx
  import ascii_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  ascii_uart_rx_if.master  bus
);

  localparam int CNT_W = $clog2(DATA_BITS);

  rx_state_e              r_state;
  rx_state_e              w_nextState;
  logic                   r_sync1;
  logic                   r_rxs;
  logic                   r_rxsPrev;
  logic [CNT_W-1:0]       r_bitCnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_dataValid;
  logic                   r_busy;
  logic                   r_frameErr;
  logic                   r_overrun;
  logic                   w_fall;
  logic                   w_tick;
  logic                   w_loadHalf;
  logic                   w_loadFull;
  logic                   w_stopTick;
  logic                   w_stopGood;
  logic                   w_xfer;
  logic                   w_load;
  logic                   w_drop;

  ascii_rx_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baudCnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_loadHalf (w_loadHalf),
    .i_loadFull (w_loadFull),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= IDLE_LEVEL;
      r_rxs     <= IDLE_LEVEL;
      r_rxsPrev <= IDLE_LEVEL;
    end else begin
      r_sync1   <= rxd;
      r_rxs     <= r_sync1;
      r_rxsPrev <= r_rxs;
    end
  end

  // Requiring the previous sample high keeps a line stuck low from re-triggering.
  assign w_fall = r_rxsPrev & ~r_rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_loadHalf  = 1'b0;
    w_loadFull  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_nextState = ST_START;
          w_loadHalf  = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_rxs) begin
            w_nextState = ST_IDLE;
          end else begin
            w_nextState = ST_DATA;
            w_loadFull  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_loadFull = 1'b1;
          if (r_bitCnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef ASCII_RX_PARITY_EN
            w_nextState = ST_PARITY;
`else
            w_nextState = ST_STOP;
`endif
          end
        end
      end
`ifdef ASCII_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_nextState = ST_STOP;
          w_loadFull  = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign w_stopTick = (r_state == ST_STOP) && w_tick;
  assign w_xfer     = r_dataValid & bus.data_ready;

`ifdef ASCII_RX_PARITY_EN
  logic r_parMis;
  logic r_parityErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parMis    <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      r_parityErr <= w_stopTick & r_rxs & r_parMis;
      if (r_state == ST_IDLE && w_fall)
        r_parMis <= 1'b0;
      else if (r_state == ST_PARITY && w_tick)
        r_parMis <= r_rxs ^ evenParity(r_shift);
    end
  end

  assign w_stopGood     = w_stopTick & r_rxs & ~r_parMis;
  assign bus.parity_err = r_parityErr;
`else
  assign w_stopGood = w_stopTick & r_rxs;
`endif

  // An accept in the stop-sample cycle frees the holding register for the new byte.
  assign w_load = w_stopGood & (~r_dataValid | bus.data_ready);
  assign w_drop = w_stopGood & r_dataValid & ~bus.data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_dataValid <= 1'b0;
      r_busy      <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_busy     <= (w_nextState != ST_IDLE);
      r_frameErr <= w_stopTick & ~r_rxs;
      r_overrun  <= w_drop;
      if (r_state == ST_IDLE && w_fall) begin
        r_bitCnt <= '0;
      end else if (r_state == ST_DATA && w_tick) begin
        r_bitCnt <= r_bitCnt + CNT_W'(1);
        r_shift  <= {r_rxs, r_shift[DATA_BITS-1:1]};
      end
      if (w_load) begin
        r_data      <= r_shift;
        r_dataValid <= 1'b1;
      end else if (w_xfer) begin
        r_dataValid <= 1'b0;
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_dataValid;
  assign bus.busy       = r_busy;
  assign bus.frame_err  = r_frameErr;
  assign bus.overrun    = r_overrun;

endmodule
